// File: rtl/ras_checkpoint_resolver_if.sv
// Bundle between the IF RAS checkpoint outputs, the EX resolution unit and the
// checkpoint resolver. The resolver connects through the slave modport.
interface ras_checkpoint_resolver_if #(
    parameter int RAS_PTR_BITS = 3,
    parameter int CNT_BITS     = 3,
    parameter int XLEN         = 32
);
    logic                    i_stall;
    logic                    i_flush;
    logic                    i_if_valid;
    logic [RAS_PTR_BITS-1:0] i_if_checkpoint_tos;
    logic [RAS_PTR_BITS:0]   i_if_checkpoint_valid_count;
    logic                    i_if_ras_predicted;
    logic [XLEN-1:0]         i_if_predicted_target;
    logic                    i_ex_valid;
    logic                    i_ex_is_return;
    logic                    i_ex_is_coroutine;
    logic [XLEN-1:0]         i_ex_actual_target;
    logic                    o_misprediction;
    logic [RAS_PTR_BITS-1:0] o_restore_tos;
    logic [RAS_PTR_BITS:0]   o_restore_valid_count;
    logic                    o_pop_after_restore;
    logic [CNT_BITS-1:0]     o_count;
    logic                    o_empty;
    logic                    o_full;
    logic                    o_error;

    modport master (
        output i_stall, i_flush, i_if_valid, i_if_checkpoint_tos,
               i_if_checkpoint_valid_count, i_if_ras_predicted, i_if_predicted_target,
               i_ex_valid, i_ex_is_return, i_ex_is_coroutine, i_ex_actual_target,
        input  o_misprediction, o_restore_tos, o_restore_valid_count,
               o_pop_after_restore, o_count, o_empty, o_full, o_error
    );

    modport slave (
        input  i_stall, i_flush, i_if_valid, i_if_checkpoint_tos,
               i_if_checkpoint_valid_count, i_if_ras_predicted, i_if_predicted_target,
               i_ex_valid, i_ex_is_return, i_ex_is_coroutine, i_ex_actual_target,
        output o_misprediction, o_restore_tos, o_restore_valid_count,
               o_pop_after_restore, o_count, o_empty, o_full, o_error
    );
endinterface

// File: rtl/ras_checkpoint_resolver.sv
// In-order queue of IF-stage RAS checkpoints; resolves returns/coroutines in EX
// and drives a one-cycle RAS restore on a target mispredict.
module ras_checkpoint_resolver #(
    parameter int RAS_DEPTH    = 8,
    parameter int RAS_PTR_BITS = $clog2(RAS_DEPTH),
    parameter int QUEUE_DEPTH  = 4,
    parameter int CNT_BITS     = $clog2(QUEUE_DEPTH + 1),
    parameter int XLEN         = 32
) (
    input logic i_clk,
    input logic i_rst,
    ras_checkpoint_resolver_if.slave bus
);
    localparam int QP_BITS = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

    typedef struct packed {
        logic [RAS_PTR_BITS-1:0] tos;
        logic [RAS_PTR_BITS:0]   vc;
        logic                    pred;
        logic [XLEN-1:0]         tgt;
    } entry_t;

    entry_t                  r_queue [QUEUE_DEPTH];
    logic [QP_BITS-1:0]      r_head;
    logic [QP_BITS-1:0]      r_tail;
    logic [CNT_BITS-1:0]     r_count;
    logic                    r_empty;
    logic                    r_full;
    logic                    r_error;
    logic                    r_misprediction;
    logic [RAS_PTR_BITS-1:0] r_restore_tos;
    logic [RAS_PTR_BITS:0]   r_restore_vc;
    logic                    r_pop;

    entry_t              w_head_entry;
    entry_t              w_new_entry;
    logic                w_deq;
    logic                w_enq_req;
    logic                w_enq;
    logic                w_tgt_miss;
    logic                w_ret_miss;
    logic                w_co_miss;
    logic                w_mispredict;
    logic                w_overflow;
    logic                w_underflow;
    logic [CNT_BITS-1:0] w_count_next;

    function automatic logic [QP_BITS-1:0] nextPtr(input logic [QP_BITS-1:0] p);
        return (p == QP_BITS'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Enqueue is blocked while the restore pulse is out: IF is still on the wrong path.
    always_comb begin
        w_head_entry = r_queue[r_head];
        w_new_entry  = '{tos:  bus.i_if_checkpoint_tos,
                         vc:   bus.i_if_checkpoint_valid_count,
                         pred: bus.i_if_ras_predicted,
                         tgt:  bus.i_if_predicted_target};
        w_deq        = bus.i_ex_valid && !bus.i_stall && !r_empty;
        w_enq_req    = bus.i_if_valid && !bus.i_stall && !r_misprediction;
        w_enq        = w_enq_req && (!r_full || w_deq);
        w_tgt_miss   = w_head_entry.tgt != bus.i_ex_actual_target;
        w_ret_miss   = bus.i_ex_is_return && !bus.i_ex_is_coroutine &&
                       (!w_head_entry.pred || w_tgt_miss);
        w_co_miss    = bus.i_ex_is_coroutine && w_tgt_miss;
        w_mispredict = w_deq && (w_ret_miss || w_co_miss);
        w_overflow   = w_enq_req && r_full && !w_deq;
        w_underflow  = bus.i_ex_valid && !bus.i_stall && r_empty;
        w_count_next = r_count;
        if (w_enq && !w_deq) begin
            w_count_next = r_count + 1'b1;
        end else if (w_deq && !w_enq) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_enq && !bus.i_flush && !w_mispredict) begin
            r_queue[r_tail] <= w_new_entry;
        end
    end

    // A mispredict wipes the queue: every younger entry was fetched down the wrong path.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            r_empty         <= 1'b1;
            r_full          <= 1'b0;
            r_error         <= 1'b0;
            r_misprediction <= 1'b0;
            r_restore_tos   <= '0;
            r_restore_vc    <= '0;
            r_pop           <= 1'b0;
        end else if (bus.i_flush) begin
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            r_empty         <= 1'b1;
            r_full          <= 1'b0;
            r_misprediction <= 1'b0;
        end else begin
            r_misprediction <= w_mispredict;
            if (w_overflow || w_underflow) begin
                r_error <= 1'b1;
            end
            if (w_mispredict) begin
                r_restore_tos <= w_head_entry.tos;
                r_restore_vc  <= w_head_entry.vc;
                r_pop         <= w_ret_miss;
                r_head        <= '0;
                r_tail        <= '0;
                r_count       <= '0;
                r_empty       <= 1'b1;
                r_full        <= 1'b0;
            end else begin
                if (w_enq) begin
                    r_tail <= nextPtr(r_tail);
                end
                if (w_deq) begin
                    r_head <= nextPtr(r_head);
                end
                r_count <= w_count_next;
                r_empty <= (w_count_next == '0);
                r_full  <= (w_count_next == CNT_BITS'(QUEUE_DEPTH));
            end
        end
    end

    assign bus.o_misprediction       = r_misprediction;
    assign bus.o_restore_tos         = r_restore_tos;
    assign bus.o_restore_valid_count = r_restore_vc;
    assign bus.o_pop_after_restore   = r_pop;
    assign bus.o_count               = r_count;
    assign bus.o_empty               = r_empty;
    assign bus.o_full                = r_full;
    assign bus.o_error               = r_error;
endmodule

// File: tb/tb_ras_checkpoint_resolver.sv
// Directed bench for ras_checkpoint_resolver: a table of single enqueue/resolve
// vectors plus hand-written multi-cycle sequences.
module tb_ras_checkpoint_resolver;
    logic clk;
    logic rst;
    int   nChecks;
    int   nErrors;
    logic [2:0] expTos;
    logic [3:0] expVc;
    logic       expPop;

    ras_checkpoint_resolver_if #(.RAS_PTR_BITS(3), .CNT_BITS(3), .XLEN(32)) bus ();

    ras_checkpoint_resolver #(
        .RAS_DEPTH(8), .QUEUE_DEPTH(4), .XLEN(32)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    typedef struct {
        logic [2:0]  tos;
        logic [3:0]  vc;
        logic        pred;
        logic [31:0] tgt;
        logic        isRet;
        logic        isCo;
        logic [31:0] act;
        logic        expMis;
        logic [2:0]  eTos;
        logic [3:0]  eVc;
        logic        ePop;
    } vec_t;

    vec_t vecs [9];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic checkRestore(input string name);
        checkOutput({name, "_tos"}, 32'(bus.o_restore_tos), 32'(expTos));
        checkOutput({name, "_vc"}, 32'(bus.o_restore_valid_count), 32'(expVc));
        checkOutput({name, "_pop"}, 32'(bus.o_pop_after_restore), 32'(expPop));
    endtask

    task automatic idleInputs();
        bus.i_stall = 0; bus.i_flush = 0; bus.i_if_valid = 0;
        bus.i_if_checkpoint_tos = 0; bus.i_if_checkpoint_valid_count = 0;
        bus.i_if_ras_predicted = 0; bus.i_if_predicted_target = 0;
        bus.i_ex_valid = 0; bus.i_ex_is_return = 0; bus.i_ex_is_coroutine = 0;
        bus.i_ex_actual_target = 0;
    endtask

    task automatic setEntry(input logic [2:0] tos, input logic [3:0] vc,
                            input logic pred, input logic [31:0] tgt);
        bus.i_if_checkpoint_tos = tos;
        bus.i_if_checkpoint_valid_count = vc;
        bus.i_if_ras_predicted = pred;
        bus.i_if_predicted_target = tgt;
    endtask

    task automatic setResolve(input logic isRet, input logic isCo, input logic [31:0] act);
        bus.i_ex_is_return = isRet;
        bus.i_ex_is_coroutine = isCo;
        bus.i_ex_actual_target = act;
    endtask

    task automatic applyStimulus(input logic [2:0] tos, input logic [3:0] vc,
                                 input logic pred, input logic [31:0] tgt);
        setEntry(tos, vc, pred, tgt);
        bus.i_if_valid = 1;
        tick();
        bus.i_if_valid = 0;
    endtask

    task automatic resolve(input logic isRet, input logic isCo, input logic [31:0] act);
        setResolve(isRet, isCo, act);
        bus.i_ex_valid = 1;
        tick();
        bus.i_ex_valid = 0;
    endtask

    initial begin
        nChecks = 0;
        nErrors = 0;
        expTos = 0; expVc = 0; expPop = 0;
        idleInputs();
        rst = 1;

        //            tos vc pred tgt      ret co  act      mis tos vc pop
        vecs[0] = '{3'd3, 4'd4, 1, 32'h100, 1, 0, 32'h100, 0, 3'd0, 4'd0, 0};
        vecs[1] = '{3'd3, 4'd4, 1, 32'h100, 1, 0, 32'h200, 1, 3'd3, 4'd4, 1};
        vecs[2] = '{3'd0, 4'd0, 0, 32'h100, 1, 0, 32'h100, 1, 3'd0, 4'd0, 1};
        vecs[3] = '{3'd5, 4'd6, 0, 32'h300, 0, 1, 32'h400, 1, 3'd5, 4'd6, 0};
        vecs[4] = '{3'd1, 4'd2, 1, 32'h500, 0, 1, 32'h500, 0, 3'd0, 4'd0, 0};
        vecs[5] = '{3'd7, 4'd8, 1, 32'h010, 0, 0, 32'h020, 0, 3'd0, 4'd0, 0};
        vecs[6] = '{3'd6, 4'd1, 0, 32'h600, 1, 1, 32'h600, 0, 3'd0, 4'd0, 0};
        vecs[7] = '{3'd2, 4'd3, 1, 32'h700, 1, 1, 32'h704, 1, 3'd2, 4'd3, 0};
        vecs[8] = '{3'd6, 4'd7, 1, 32'h800, 1, 0, 32'h800, 0, 3'd0, 4'd0, 0};

        #12;
        checkOutput("rst_count", 32'(bus.o_count), 0);
        checkOutput("rst_empty", 32'(bus.o_empty), 1);
        checkOutput("rst_full", 32'(bus.o_full), 0);
        checkOutput("rst_mis", 32'(bus.o_misprediction), 0);
        checkOutput("rst_err", 32'(bus.o_error), 0);
        checkRestore("rst");
        rst = 0;
        tick();

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].tos, vecs[i].vc, vecs[i].pred, vecs[i].tgt);
            resolve(vecs[i].isRet, vecs[i].isCo, vecs[i].act);
            checkOutput($sformatf("vec%0d_mis", i), 32'(bus.o_misprediction), 32'(vecs[i].expMis));
            if (vecs[i].expMis) begin
                expTos = vecs[i].eTos; expVc = vecs[i].eVc; expPop = vecs[i].ePop;
            end
            checkRestore($sformatf("vec%0d", i));
            tick();
            checkOutput($sformatf("vec%0d_pulse_end", i), 32'(bus.o_misprediction), 0);
            checkOutput($sformatf("vec%0d_count", i), 32'(bus.o_count), 0);
        end

        // Mispredict with two younger entries; enqueue during the pulse is dropped
        applyStimulus(3'd3, 4'd4, 1, 32'h100);
        applyStimulus(3'd1, 4'd1, 1, 32'h110);
        applyStimulus(3'd2, 4'd2, 1, 32'h120);
        checkOutput("young_count3", 32'(bus.o_count), 3);
        resolve(1, 0, 32'h200);
        expTos = 3; expVc = 4; expPop = 1;
        checkOutput("young_mis", 32'(bus.o_misprediction), 1);
        checkRestore("young");
        applyStimulus(3'd5, 4'd5, 1, 32'h130);
        checkOutput("young_pulse_end", 32'(bus.o_misprediction), 0);
        checkOutput("young_count0", 32'(bus.o_count), 0);
        checkOutput("young_empty", 32'(bus.o_empty), 1);
        checkRestore("young_hold");

        // Stall holds the resolve; pulse lasts one cycle even if stalled after
        applyStimulus(3'd4, 4'd5, 1, 32'h40);
        setResolve(1, 0, 32'h44);
        bus.i_ex_valid = 1; bus.i_if_valid = 1; bus.i_stall = 1;
        tick();
        checkOutput("stall_mis", 32'(bus.o_misprediction), 0);
        checkOutput("stall_count", 32'(bus.o_count), 1);
        bus.i_stall = 0; bus.i_if_valid = 0;
        tick();
        expTos = 4; expVc = 5; expPop = 1;
        checkOutput("unstall_mis", 32'(bus.o_misprediction), 1);
        checkRestore("unstall");
        bus.i_stall = 1;
        tick();
        checkOutput("stall_pulse_end", 32'(bus.o_misprediction), 0);
        bus.i_stall = 0; bus.i_ex_valid = 0;
        checkOutput("stall_empty", 32'(bus.o_empty), 1);

        // Flush cancels a same-cycle mispredict
        applyStimulus(3'd6, 4'd6, 1, 32'h60);
        applyStimulus(3'd7, 4'd7, 1, 32'h70);
        bus.i_flush = 1;
        resolve(1, 0, 32'h99);
        bus.i_flush = 0;
        checkOutput("flush_mis", 32'(bus.o_misprediction), 0);
        checkOutput("flush_count", 32'(bus.o_count), 0);
        checkOutput("flush_empty", 32'(bus.o_empty), 1);
        checkOutput("flush_err", 32'(bus.o_error), 0);
        checkRestore("flush_hold");
        tick();
        checkOutput("flush_mis_late", 32'(bus.o_misprediction), 0);

        // Fill, stream across the wrap, then overflow and check FIFO order
        for (int k = 0; k < 4; k++) begin
            applyStimulus(3'(k), 4'(k + 1), 1, 32'h1000 + k);
        end
        checkOutput("fill_full", 32'(bus.o_full), 1);
        checkOutput("fill_count", 32'(bus.o_count), 4);
        for (int j = 0; j < 10; j++) begin
            setEntry(3'(4 + j), 4'(5 + j), 1, 32'h1004 + j);
            setResolve(0, 0, 32'h0);
            bus.i_if_valid = 1; bus.i_ex_valid = 1;
            tick();
            checkOutput($sformatf("stream%0d_full", j), 32'(bus.o_full), 1);
            checkOutput($sformatf("stream%0d_mis", j), 32'(bus.o_misprediction), 0);
        end
        bus.i_if_valid = 0; bus.i_ex_valid = 0;
        checkOutput("stream_err", 32'(bus.o_error), 0);
        checkOutput("stream_count", 32'(bus.o_count), 4);
        applyStimulus(3'd1, 4'd15, 1, 32'h100e);
        checkOutput("ovf_err", 32'(bus.o_error), 1);
        checkOutput("ovf_count", 32'(bus.o_count), 4);
        resolve(0, 1, 32'h100a);
        checkOutput("order10_mis", 32'(bus.o_misprediction), 0);
        checkOutput("order10_count", 32'(bus.o_count), 3);
        resolve(1, 0, 32'hdead);
        expTos = 3; expVc = 12; expPop = 1;
        checkOutput("order11_mis", 32'(bus.o_misprediction), 1);
        checkRestore("order11");
        tick();
        bus.i_flush = 1;
        tick();
        bus.i_flush = 0;
        checkOutput("flush_err_sticky", 32'(bus.o_error), 1);

        // Reset mid-stream with three entries queued
        applyStimulus(3'd1, 4'd1, 1, 32'h1);
        applyStimulus(3'd2, 4'd2, 1, 32'h2);
        applyStimulus(3'd3, 4'd3, 1, 32'h3);
        checkOutput("mid_count3", 32'(bus.o_count), 3);
        rst = 1;
        #2;
        expTos = 0; expVc = 0; expPop = 0;
        checkOutput("mid_rst_count", 32'(bus.o_count), 0);
        checkOutput("mid_rst_empty", 32'(bus.o_empty), 1);
        checkOutput("mid_rst_err", 32'(bus.o_error), 0);
        checkRestore("mid_rst");
        rst = 0;
        tick();

        // Resolve on an empty queue flags underflow without a restore
        resolve(1, 0, 32'h5);
        checkOutput("udf_err", 32'(bus.o_error), 1);
        checkOutput("udf_mis", 32'(bus.o_misprediction), 0);
        checkOutput("udf_count", 32'(bus.o_count), 0);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end
endmodule
